// File: rtl/ghost_position_tracker_pkg.sv
// Shared playfield geometry, spawn points and FSM encoding for the ghost position tracker.
package ghost_position_tracker_pkg;

  localparam int unsigned WIDTH        = 640;
  localparam int unsigned HEIGHT       = 480;
  localparam int unsigned TILE_SIZE    = 20;
  localparam int unsigned TILE_ROW_NUM = HEIGHT / TILE_SIZE;
  localparam int unsigned TILE_COL_NUM = WIDTH / TILE_SIZE;
  localparam int unsigned NUM_TILES    = TILE_ROW_NUM * TILE_COL_NUM;

  localparam int unsigned X_W        = $clog2(WIDTH);
  localparam int unsigned Y_W        = $clog2(HEIGHT);
  localparam int unsigned TILE_IDX_W = $clog2(NUM_TILES);

  localparam int unsigned GHOST1_SPAWN_POINT_X = 300;
  localparam int unsigned GHOST1_SPAWN_POINT_Y = 200;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_MOVE   = 2'd3;

endpackage

// File: rtl/ghost_position_tracker_pixel_tick_divider.sv
// Free-running clock divider producing one tick every PIXEL_DIV cycles of run; holds while run is low.
module pixel_tick_divider #(
  parameter int unsigned PIXEL_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXEL_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Combinational so the consumer updates on the same edge the count wraps.
  assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ghost_position_tracker.sv
// Latches a ghost controller proposal, validates it against the wall map, then
// walks the committed position one pixel per divider tick toward the target.
module ghost_position_tracker
  import ghost_position_tracker_pkg::*;
#(
  parameter int unsigned SPAWN_X   = GHOST1_SPAWN_POINT_X,
  parameter int unsigned SPAWN_Y   = GHOST1_SPAWN_POINT_Y,
  parameter int unsigned SPEED     = TILE_SIZE,
  parameter int unsigned PIXEL_DIV = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [X_W-1:0]       next_x,
  input  logic [Y_W-1:0]       next_y,
  input  logic [NUM_TILES-1:0] tilemap_walls,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic                 moving,
  output logic                 step_done,
  output logic                 blocked
);

  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  localparam logic [X_W-1:0] SPEED_X  = X_W'(SPEED);
  localparam logic [Y_W-1:0] SPEED_Y  = Y_W'(SPEED);
  localparam logic [X_W-1:0] WIDTH_X  = X_W'(WIDTH);
  localparam logic [Y_W-1:0] HEIGHT_Y = Y_W'(HEIGHT);

  logic [1:0]          state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  pos_t                tgt_q, tgt_d;
  logic [X_W-1:0]      x_d;
  logic [Y_W-1:0]      y_d;
  logic                moving_d, step_done_d, blocked_d;

  logic                  tick;
  logic                  dx_ne, dy_ne, in_bounds, aligned, wall_hit, legal;
  logic [X_W-1:0]        dist_x;
  logic [Y_W-1:0]        dist_y;
  logic [TILE_IDX_W-1:0] tile_idx;

  pixel_tick_divider #(
    .PIXEL_DIV(PIXEL_DIV)
  ) u_pixel_tick_divider (
    .clk  (clk),
    .reset(reset),
    .run  ((state_q == ST_MOVE) && enable),
    .tick (tick)
  );

  // Legality of the latched target against the committed position and wall map.
  always_comb begin
    dx_ne     = (tgt_q.x != x);
    dy_ne     = (tgt_q.y != y);
    dist_x    = (tgt_q.x > x) ? tgt_q.x - x : x - tgt_q.x;
    dist_y    = (tgt_q.y > y) ? tgt_q.y - y : y - tgt_q.y;
    in_bounds = (tgt_q.x < WIDTH_X) && (tgt_q.y < HEIGHT_Y);
    aligned   = ((tgt_q.x % SPEED_X) == '0) && ((tgt_q.y % SPEED_Y) == '0);
    tile_idx  = TILE_IDX_W'(tgt_q.y / SPEED_Y) * TILE_IDX_W'(TILE_COL_NUM)
              + TILE_IDX_W'(tgt_q.x / SPEED_X);
    wall_hit  = !in_bounds || tilemap_walls[tile_idx];
    legal     = (dx_ne ^ dy_ne)
              && (dx_ne ? (dist_x == SPEED_X) : (dist_y == SPEED_Y))
              && in_bounds && aligned && !wall_hit;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tgt_d       = tgt_q;
    x_d         = x;
    y_d         = y;
    moving_d    = 1'b0;
    step_done_d = 1'b0;
    blocked_d   = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q != SETTLE_LAST) begin
          settle_d = settle_q + SETTLE_W'(1);
        end else if (enable) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        tgt_d.x = next_x;
        tgt_d.y = next_y;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (legal) begin
          moving_d = 1'b1;
          state_d  = ST_MOVE;
        end else begin
          blocked_d = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_MOVE: begin
        moving_d = 1'b1;
        if (tick) begin
          if (x != tgt_q.x) x_d = (tgt_q.x > x) ? x + X_W'(1) : x - X_W'(1);
          if (y != tgt_q.y) y_d = (tgt_q.y > y) ? y + Y_W'(1) : y - Y_W'(1);
          if ((x_d == tgt_q.x) && (y_d == tgt_q.y)) begin
            moving_d    = 1'b0;
            step_done_d = 1'b1;
            state_d     = ST_SETTLE;
          end
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SETTLE;
      settle_q  <= '0;
      tgt_q     <= '0;
      x         <= X_W'(SPAWN_X);
      y         <= Y_W'(SPAWN_Y);
      moving    <= 1'b0;
      step_done <= 1'b0;
      blocked   <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      tgt_q     <= tgt_d;
      x         <= x_d;
      y         <= y_d;
      moving    <= moving_d;
      step_done <= step_done_d;
      blocked   <= blocked_d;
    end
  end

endmodule

// File: tb/tb_ghost_position_tracker.sv
// Self-checking bench for ghost_position_tracker: directed scenarios plus a random walk
// checked against a rule-level legality model.
module tb_ghost_position_tracker;
  import ghost_position_tracker_pkg::*;

  localparam int DIV         = 2;
  localparam int SPD         = 20;
  localparam int SPAWN_X0    = 300;
  localparam int SPAWN_Y0    = 200;
  localparam int PIX_W       = 640;
  localparam int PIX_H       = 480;
  localparam int COLS        = 32;
  localparam int TILES       = 768;
  localparam int STEP_CYCLES = SPD * DIV;
  localparam int TIMEOUT     = 200;

  logic                 clk    = 1'b0;
  logic                 reset  = 1'b1;
  logic                 enable = 1'b1;
  logic [X_W-1:0]       next_x = X_W'(SPAWN_X0);
  logic [Y_W-1:0]       next_y = Y_W'(SPAWN_Y0);
  logic [NUM_TILES-1:0] walls  = '0;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic                 moving, step_done, blocked;

  int checks = 0;
  int errors = 0;
  int mx = SPAWN_X0;
  int my = SPAWN_Y0;

  always #5 clk = ~clk;

  ghost_position_tracker #(
    .SPAWN_X  (SPAWN_X0),
    .SPAWN_Y  (SPAWN_Y0),
    .SPEED    (SPD),
    .PIXEL_DIV(DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .next_x       (next_x),
    .next_y       (next_y),
    .tilemap_walls(walls),
    .x            (x),
    .y            (y),
    .moving       (moving),
    .step_done    (step_done),
    .blocked      (blocked)
  );

  // Rule-level legality of a proposal from (cx,cy) to (nx,ny).
  function automatic bit model_legal(input int cx, input int cy, input int nx, input int ny,
                                     input logic [TILES-1:0] w);
    int dx, dy, adx, ady;
    dx  = nx - cx;
    dy  = ny - cy;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    if (nx >= PIX_W || ny >= PIX_H) return 1'b0;
    if ((dx != 0) == (dy != 0)) return 1'b0;
    if (adx + ady != SPD) return 1'b0;
    if ((nx % SPD) != 0 || (ny % SPD) != 0) return 1'b0;
    if (w[(ny / SPD) * COLS + nx / SPD]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mx = SPAWN_X0;
    my = SPAWN_Y0;
  endtask

  // Presents a proposal and waits for the step_done/blocked outcome.
  task automatic run_step(input logic [X_W-1:0] nx, input logic [Y_W-1:0] ny,
                          output bit done, output bit blk, output int mov, output bit timed_out);
    next_x = nx;
    next_y = ny;
    done = 1'b0;
    blk = 1'b0;
    mov = 0;
    timed_out = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (moving) mov++;
      if (step_done || blocked) begin
        done = step_done;
        blk = blocked;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if (x !== X_W'(SPAWN_X0)) begin errors++; $display("FAIL reset_x got %0d exp %0d", x, SPAWN_X0); end
    checks++; if (y !== Y_W'(SPAWN_Y0)) begin errors++; $display("FAIL reset_y got %0d exp %0d", y, SPAWN_Y0); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %b exp 0", moving); end
    checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL reset_step_done got %b exp 0", step_done); end
    checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL reset_blocked got %b exp 0", blocked); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mx = SPAWN_X0;
    my = SPAWN_Y0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (moving !== 1'b0 || x !== X_W'(SPAWN_X0)) begin
      errors++; $display("FAIL post_reset_idle got x=%0d moving=%b exp x=%0d moving=0", x, moving, SPAWN_X0);
    end
  endtask

  task automatic test_wall();
    bit done, blk, to, legal;
    int mov;
    walls = '0;
    walls[336] = 1'b1;
    legal = model_legal(mx, my, 320, 200, walls);
    run_step(X_W'(320), Y_W'(200), done, blk, mov, to);
    checks++; if (to) begin errors++; $display("FAIL wall_timeout no outcome within %0d cycles", TIMEOUT); end
    checks++; if (blk !== !legal || done !== legal) begin
      errors++; $display("FAIL wall_outcome got done=%b blocked=%b exp done=%b blocked=%b", done, blk, legal, !legal);
    end
    checks++; if (mov != 0) begin errors++; $display("FAIL wall_moving got %0d moving cycles exp 0", mov); end
    checks++; if (x !== X_W'(mx) || y !== Y_W'(my)) begin
      errors++; $display("FAIL wall_pos got (%0d,%0d) exp (%0d,%0d)", x, y, mx, my);
    end
    @(posedge clk); #1;
    checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL wall_pulse_width blocked got %b exp 0", blocked); end
    walls = '0;
  endtask

  task automatic test_illegal();
    int px[6] = '{320, 340, 300, 310, 280, 300};
    int py[6] = '{220, 200, 200, 200, 180, 205};
    bit done, blk, to, legal;
    int mov;
    walls = '0;
    for (int i = 0; i < 6; i++) begin
      legal = model_legal(mx, my, px[i], py[i], walls);
      run_step(X_W'(px[i]), Y_W'(py[i]), done, blk, mov, to);
      checks++; if (to || blk !== !legal || done !== legal || mov != 0) begin
        errors++;
        $display("FAIL illegal_%0d got done=%b blocked=%b mov=%0d timeout=%b exp done=%b blocked=%b mov=0",
                 i, done, blk, mov, to, legal, !legal);
      end
      checks++; if (x !== X_W'(mx) || y !== Y_W'(my)) begin
        errors++; $display("FAIL illegal_pos_%0d got (%0d,%0d) exp (%0d,%0d)", i, x, y, mx, my);
      end
    end
  endtask

  task automatic test_move_basic();
    bit rose, saw_blk;
    int start;
    start = mx;
    rose = 1'b0;
    saw_blk = 1'b0;
    walls = '0;
    next_x = X_W'(mx + SPD);
    next_y = Y_W'(my);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (blocked) saw_blk = 1'b1;
      if (moving) begin rose = 1'b1; break; end
    end
    checks++; if (!rose) begin errors++; $display("FAIL move_start moving never rose within %0d cycles", TIMEOUT); return; end
    for (int k = 0; k <= STEP_CYCLES; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 1) walls = '1;
      if (blocked) saw_blk = 1'b1;
      checks++; if (x !== X_W'(start + k / DIV) || y !== Y_W'(my)) begin
        errors++; $display("FAIL move_trace_%0d got (%0d,%0d) exp (%0d,%0d)", k, x, y, start + k / DIV, my);
      end
      checks++; if (moving !== (k < STEP_CYCLES) || step_done !== (k == STEP_CYCLES)) begin
        errors++; $display("FAIL move_flags_%0d got moving=%b step_done=%b exp moving=%b step_done=%b",
                           k, moving, step_done, k < STEP_CYCLES, k == STEP_CYCLES);
      end
    end
    checks++; if (saw_blk) begin errors++; $display("FAIL move_blocked got blocked pulse exp none"); end
    walls = '0;
    mx = start + SPD;
  endtask

  task automatic test_pause();
    bit found, fin;
    int mov;
    do_reset();
    next_x = X_W'(mx + SPD);
    next_y = Y_W'(my);
    mov = 0;
    found = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (moving) mov++;
      if (x == X_W'(mx + SPD / 2)) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL pause_reach x never reached %0d, got %0d", mx + SPD / 2, x); return; end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (moving) mov++;
      checks++; if (x !== X_W'(mx + SPD / 2) || moving !== 1'b1) begin
        errors++; $display("FAIL pause_hold_%0d got x=%0d moving=%b exp x=%0d moving=1", i, x, moving, mx + SPD / 2);
      end
    end
    enable = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (moving) mov++;
      if (step_done) begin fin = 1'b1; break; end
    end
    checks++; if (!fin) begin errors++; $display("FAIL pause_finish no step_done within %0d cycles", TIMEOUT); end
    checks++; if (mov != STEP_CYCLES + 10) begin
      errors++; $display("FAIL pause_duration got %0d moving cycles exp %0d", mov, STEP_CYCLES + 10);
    end
    checks++; if (x !== X_W'(mx + SPD)) begin errors++; $display("FAIL pause_final_x got %0d exp %0d", x, mx + SPD); end
    mx = mx + SPD;
  endtask

  task automatic test_reset_mid_move();
    bit found, done, blk, to;
    int mov;
    do_reset();
    next_x = X_W'(mx + SPD);
    next_y = Y_W'(my);
    found = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (x == X_W'(mx + 7)) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_reach x never reached %0d, got %0d", mx + 7, x); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (x !== X_W'(SPAWN_X0) || y !== Y_W'(SPAWN_Y0) || moving !== 1'b0) begin
      errors++; $display("FAIL midreset_async got (%0d,%0d) moving=%b exp (%0d,%0d) moving=0",
                         x, y, moving, SPAWN_X0, SPAWN_Y0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mx = SPAWN_X0;
    my = SPAWN_Y0;
    run_step(X_W'(mx + SPD), Y_W'(my), done, blk, mov, to);
    checks++; if (to || done !== 1'b1 || blk !== 1'b0 || mov != STEP_CYCLES) begin
      errors++; $display("FAIL midreset_resume got done=%b blocked=%b mov=%0d timeout=%b exp done=1 blocked=0 mov=%0d",
                         done, blk, mov, to, STEP_CYCLES);
    end
    mx = mx + SPD;
    checks++; if (x !== X_W'(mx)) begin errors++; $display("FAIL midreset_final_x got %0d exp %0d", x, mx); end
  endtask

  task automatic test_bounds();
    bit done, blk, to, legal;
    int mov;
    logic [X_W-1:0] wx;
    logic [Y_W-1:0] wy;
    walls = '0;
    while (mx > 0) begin
      run_step(X_W'(mx - SPD), Y_W'(my), done, blk, mov, to);
      mx = mx - SPD;
      checks++; if (to || done !== 1'b1 || x !== X_W'(mx)) begin
        errors++; $display("FAIL bounds_walk_x got done=%b x=%0d exp done=1 x=%0d", done, x, mx);
      end
    end
    wx = '0;
    wx = wx - X_W'(SPD);
    legal = model_legal(mx, my, int'(wx), my, walls);
    run_step(wx, Y_W'(my), done, blk, mov, to);
    checks++; if (to || blk !== !legal || done !== legal || x !== X_W'(0)) begin
      errors++; $display("FAIL bounds_x_wrap got done=%b blocked=%b x=%0d exp done=%b blocked=%b x=0",
                         done, blk, x, legal, !legal);
    end
    while (my > 0) begin
      run_step(X_W'(mx), Y_W'(my - SPD), done, blk, mov, to);
      my = my - SPD;
      checks++; if (to || done !== 1'b1 || y !== Y_W'(my)) begin
        errors++; $display("FAIL bounds_walk_y got done=%b y=%0d exp done=1 y=%0d", done, y, my);
      end
    end
    wy = '0;
    wy = wy - Y_W'(SPD);
    legal = model_legal(mx, my, mx, int'(wy), walls);
    run_step(X_W'(mx), wy, done, blk, mov, to);
    checks++; if (to || blk !== !legal || done !== legal || y !== Y_W'(0)) begin
      errors++; $display("FAIL bounds_y_wrap got done=%b blocked=%b y=%0d exp done=%b blocked=%b y=0",
                         done, blk, y, legal, !legal);
    end
  endtask

  task automatic test_random();
    bit done, blk, to, legal;
    int mov, kind, d, nxi, nyi, sx, sy;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    for (int it = 0; it < 60; it++) begin
      for (int t = 0; t < TILES; t++) walls[t] = ($urandom_range(0, 4) == 0);
      kind = int'($urandom_range(0, 9));
      d = int'($urandom_range(0, 3));
      sx = ($urandom_range(0, 1) == 0) ? SPD : -SPD;
      sy = ($urandom_range(0, 1) == 0) ? SPD : -SPD;
      if (kind <= 5) begin
        nxi = mx + ((d == 0) ? SPD : (d == 1) ? -SPD : 0);
        nyi = my + ((d == 2) ? SPD : (d == 3) ? -SPD : 0);
      end else if (kind == 6) begin
        nxi = mx + sx; nyi = my + sy;
      end else if (kind == 7) begin
        nxi = mx + 2 * sx; nyi = my;
      end else if (kind == 8) begin
        nxi = mx; nyi = my;
      end else begin
        nxi = int'($urandom_range(0, 1023)); nyi = int'($urandom_range(0, 511));
      end
      nx = X_W'(nxi);
      ny = Y_W'(nyi);
      legal = model_legal(mx, my, int'(nx), int'(ny), walls);
      run_step(nx, ny, done, blk, mov, to);
      if (legal) begin mx = int'(nx); my = int'(ny); end
      checks++; if (to || blk !== !legal || done !== legal) begin
        errors++; $display("FAIL rand_outcome_%0d to (%0d,%0d) got done=%b blocked=%b timeout=%b exp done=%b blocked=%b",
                           it, nx, ny, done, blk, to, legal, !legal);
      end
      checks++; if (mov != (legal ? STEP_CYCLES : 0)) begin
        errors++; $display("FAIL rand_duration_%0d got %0d exp %0d", it, mov, legal ? STEP_CYCLES : 0);
      end
      checks++; if (x !== X_W'(mx) || y !== Y_W'(my)) begin
        errors++; $display("FAIL rand_pos_%0d got (%0d,%0d) exp (%0d,%0d)", it, x, y, mx, my);
      end
    end
    walls = '0;
  endtask

  initial begin
    test_reset();
    test_wall();
    test_illegal();
    test_move_basic();
    test_pause();
    test_reset_mid_move();
    test_bounds();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_position_tracker.md
Name: ghost_position_tracker

Overview:
- Consumer end of the ghost-controller interface.
- A ghost controller proposes `next_x`/`next_y` from the current `x`/`y`. This block latches that proposal, validates it against the wall tilemap, then walks the committed on-screen position one pixel at a time toward the target. On arrival the new `x`/`y` is fed back to the controller.
- One instance per ghost. It sits between the ghost controller and the renderer/collision logic.

Parameters:
- SPAWN_X, `GHOST1_SPAWN_POINT_X`: reset x position in pixels, tile-aligned.
- SPAWN_Y, `GHOST1_SPAWN_POINT_Y`: reset y position in pixels, tile-aligned.
- SPEED, 20: step size in pixels. Equals the tile size and must match the controller's speed.
- PIXEL_DIV, 250000: clk cycles per 1-pixel move, must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = freeze at the next pixel boundary.
- next_x  in  $clog2(`WIDTH)  proposed target x from the controller.
- next_y  in  $clog2(`HEIGHT)  proposed target y from the controller.
- tilemap_walls  in  `tile_row_num*`tile_col_num  wall bits; bit index = row*`tile_col_num + col.
- x  out  $clog2(`WIDTH)  committed pixel x, fed to the controller and renderer.
- y  out  $clog2(`HEIGHT)  committed pixel y.
- moving  out  1  high while in MOVE.
- step_done  out  1  1-cycle pulse when x/y reaches a tile-aligned target.
- blocked  out  1  1-cycle pulse when a proposal is rejected.

Behaviour:
- Reset (async, reset==0):
  - x=SPAWN_X, y=SPAWN_Y.
  - moving=0, step_done=0, blocked=0.
  - state=SETTLE, settle counter=0, pixel divider=0.
  - Reset asserted mid-MOVE abandons the step immediately.
- All outputs are registered.
- States: SETTLE, SAMPLE, CHECK, MOVE.
- SETTLE:
  - Wait 2 cycles so the controller's registered `next_x`/`next_y` reflects the current x/y.
  - Then go to SAMPLE if enable=1, otherwise stay.
- SAMPLE: latch tx=next_x, ty=next_y; go to CHECK.
- CHECK: the proposal is legal only if all of the following hold:
  - exactly one axis differs;
  - the absolute difference on that axis equals SPEED;
  - tx < `WIDTH and ty < `HEIGHT. This also catches 0-SPEED underflow, which wraps to a large value.
  - tx and ty are multiples of SPEED;
  - tilemap_walls[(ty/SPEED)*`tile_col_num + tx/SPEED] == 0.
- CHECK outcome:
  - Legal: go to MOVE.
  - Illegal: pulse blocked, leave x/y unchanged, go to SETTLE.
  - A diagonal, zero-length or non-SPEED jump is treated as illegal.
- MOVE:
  - moving=1. The pixel divider counts 0..PIXEL_DIV-1.
  - On terminal count, move the differing axis by ±1 toward the target.
  - When x==tx and y==ty after an update: moving=0, pulse step_done in the same cycle as the final update, go to SETTLE.
  - Exactly SPEED*PIXEL_DIV cycles from MOVE entry to step_done.
- enable=0 during MOVE: the divider holds and position holds (pause). When enable returns, the move resumes with no lost or extra pixel.
- tilemap_walls is sampled only in CHECK. Later changes do not abort a move in progress.
- step_done and blocked are never high together.
- With PIXEL_DIV=1, one pixel moves per cycle.

Decomposition:
- Shared package (define.v): `WIDTH, `HEIGHT, `tile_row_num, `tile_col_num, spawn points, `dir_* codes. Add `TILE_SIZE (20) and an FSM state encoding for ghost_position_tracker.
- One sub-module: pixel_tick_divider (parameter PIXEL_DIV; inputs clk, reset, run; output tick). Reused by the pacman mover.

Test Plan:
- Reset with SPAWN=(300,200), PIXEL_DIV=2 → x=300, y=200, moving=0 immediately; state SETTLE.
- Clear map, next=(320,200) → blocked never pulses. step_done after 40 cycles of MOVE, x increments 1 pixel per 2 cycles, final x=320.
- Wall bit set at row 10, col 16 (index 336), next=(320,200) → blocked pulse, x/y stay (300,200), moving stays 0.
- Illegal proposals each → blocked, no motion:
  - (320,220): diagonal.
  - (340,200): 40-pixel jump.
  - at x=0, next_x=0-20 wrapped: out of bounds.
- enable dropped for 10 cycles mid-MOVE at x=310 → x frozen at 310, moving stays 1. Completes at 320, total move time 40+10 cycles.
- reset asserted at x=307 mid-MOVE → x=300, y=200 asynchronously; moving=0. After release, normal operation resumes from SETTLE.
